// File: rtl/lab2_seq_ctrl.sv
// Replays a programmed list of codes into the lab2 recognizer, two cycles per step (DRIVE, SAMPLE).
// Done pulses in cycle 2N+1 after start; start and prog_wr are ignored while a run is active.
module lab2_seq_ctrl #(
   parameter int XW    = 3,
   parameter int DEPTH = 8,
   parameter int LENW  = $clog2(DEPTH) + 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     prog_wr,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [XW-1:0]            prog_data,
   input  logic [LENW-1:0]          len,
   input  logic                     start,
   output logic [XW-1:0]            x_out,
   output logic                     x_valid,
   input  logic                     z_in,
   input  logic                     error_in,
   output logic                     busy,
   output logic                     done,
   output logic                     aborted,
   output logic [$clog2(DEPTH)-1:0] step,
   output logic [DEPTH-1:0]         z_vec
);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

   state_t                           state_q, state_d;
   logic [DEPTH-1:0][XW-1:0]         mem_q, mem_d;
   logic [LENW-1:0]                  len_l_q, len_l_d;
   logic [$clog2(DEPTH)-1:0]         step_q, step_d;
   logic [DEPTH-1:0]                 z_vec_q, z_vec_d;
   logic [XW-1:0]                    x_out_q, x_out_d;
   logic                             x_valid_q, x_valid_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;
   logic                             aborted_q, aborted_d;
   logic                             last_step;

   assign last_step = (LENW'(step_q) == (len_l_q - LENW'(1)));

   always_comb begin
      state_d   = state_q;
      mem_d     = mem_q;
      len_l_d   = len_l_q;
      step_d    = step_q;
      z_vec_d   = z_vec_q;
      x_out_d   = x_out_q;
      x_valid_d = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      case (state_q)
         S_IDLE: begin
            if (prog_wr) begin
               mem_d[prog_addr] = prog_data;
            end
            // Read through mem_d so a write on the start edge is seen by step 0.
            if (start && (len != '0)) begin
               state_d   = S_DRIVE;
               step_d    = '0;
               z_vec_d   = '0;
               aborted_d = 1'b0;
               len_l_d   = (len > LENW'(DEPTH)) ? LENW'(DEPTH) : len;
               x_out_d   = mem_d[0];
               x_valid_d = 1'b1;
               busy_d    = 1'b1;
            end
         end
         S_DRIVE: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            z_vec_d[step_q] = z_in;
            if (error_in) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
               done_d    = 1'b1;
            end else if (last_step) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               state_d   = S_DRIVE;
               step_d    = step_q + 1'b1;
               x_out_d   = mem_q[step_q + 1'b1];
               x_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            x_out_d = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mem_q     <= '0;
         len_l_q   <= '0;
         step_q    <= '0;
         z_vec_q   <= '0;
         x_out_q   <= '0;
         x_valid_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_q     <= mem_d;
         len_l_q   <= len_l_d;
         step_q    <= step_d;
         z_vec_q   <= z_vec_d;
         x_out_q   <= x_out_d;
         x_valid_q <= x_valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;
   assign step    = step_q;
   assign z_vec   = z_vec_q;

endmodule

// File: tb/tb_lab2_seq_ctrl.sv
// Scoreboard bench for lab2_seq_ctrl: expected codes are queued per run and popped on each x_valid.
// A small datapath model answers z = registered x[0]; error_in is injected in a chosen SAMPLE cycle.
module tb_lab2_seq_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       prog_wr = 1'b0;
   logic [2:0] prog_addr = '0;
   logic [2:0] prog_data = '0;
   logic [3:0] len = '0;
   logic       start = 1'b0;
   logic [2:0] x_out;
   logic       x_valid;
   logic       z_in;
   logic       error_in;
   logic       busy;
   logic       done;
   logic       aborted;
   logic [2:0] step;
   logic [7:0] z_vec;

   int         errors = 0;
   int         checks = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mem_model[8];
   logic [2:0] dp_x = '0;
   int         drv_cnt = 0;
   int         err_target = -1;

   lab2_seq_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .prog_wr   (prog_wr),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .len       (len),
      .start     (start),
      .x_out     (x_out),
      .x_valid   (x_valid),
      .z_in      (z_in),
      .error_in  (error_in),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .step      (step),
      .z_vec     (z_vec)
   );

   always #5 clock = ~clock;

   // Datapath model: x registered on the edge closing DRIVE, z valid in SAMPLE.
   always @(posedge clock) begin
      if (x_valid) begin
         dp_x    <= x_out;
         drv_cnt <= drv_cnt + 1;
      end
   end
   assign z_in     = dp_x[0];
   assign error_in = (err_target >= 0) && busy && !x_valid && (drv_cnt == err_target);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard consumer: any drive with an empty queue compares against an impossible code.
   always @(negedge clock) begin
      logic [31:0] e;
      if (x_valid) begin
         e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFF;
         check("x_out", 32'(x_out), e);
      end
   end

   task automatic idle_chk();
      @(negedge clock);
      check("done_1cyc", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_x", 32'(x_out), 0);
   endtask

   task automatic run_seq(input int len_in, input int err_step, input bit poke, input bit early);
      int         n;
      int         cyc;
      logic [7:0] zexp;
      n = (len_in > 8) ? 8 : len_in;
      if (err_step >= 0 && err_step < n) n = err_step + 1;
      zexp = '0;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mem_model[i]);
         zexp[i] = mem_model[i][0];
      end
      err_target = (err_step >= 0) ? drv_cnt + err_step + 1 : -1;
      len   = 4'(len_in);
      start = 1'b1;
      if (early) begin
         @(negedge clock);
         check("b2b_ign", 32'(busy), 0);
      end
      @(negedge clock);
      start   = 1'b0;
      prog_wr = 1'b0;
      cyc     = 1;
      check("c1_xv", 32'(x_valid), 1);
      check("c1_zvec", 32'(z_vec), 0);
      check("c1_abort", 32'(aborted), 0);
      check("c1_step", 32'(step), 0);
      while (!done && cyc < 60) begin
         if (poke && cyc == 5) begin
            prog_wr = 1'b1; prog_addr = 3'd0; prog_data = 3'd7; start = 1'b1;
         end else if (poke && cyc == 6) begin
            prog_wr = 1'b0; start = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      prog_wr = 1'b0;
      start   = 1'b0;
      check("done_cyc", 32'(cyc), 32'(2 * n + 1));
      check("busy_dn", 32'(busy), 1);
      check("z_vec", 32'(z_vec), 32'(zexp));
      check("aborted", 32'(aborted), (err_step >= 0) ? 1 : 0);
      check("step", 32'(step), 32'(n - 1));
      check("q_empty", 32'(exp_q.size()), 0);
      err_target = -1;
   endtask

   initial begin
      int cyc;
      int base;
      int dcnt;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_xv", 32'(x_valid), 0);
      check("rst_x", 32'(x_out), 0);
      check("rst_zvec", 32'(z_vec), 0);
      check("rst_step", 32'(step), 0);
      for (int i = 0; i < 8; i++) begin
         prog_wr = 1'b1; prog_addr = 3'(i); prog_data = 3'(i);
         mem_model[i] = 3'(i);
         @(negedge clock);
      end
      prog_wr = 1'b0;

      run_seq(8, -1, 0, 0);          // full program, z_vec = 8'b10101010
      idle_chk();
      run_seq(3, -1, 0, 0);          // short run
      idle_chk();
      run_seq(8, 4, 0, 0);           // error in SAMPLE of step 4
      run_seq(3, -1, 0, 1);          // start in DONE ignored, next cycle accepted
      idle_chk();

      len = 4'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("len0_busy", 32'(busy), 0);
      check("len0_xv", 32'(x_valid), 0);
      run_seq(15, -1, 0, 0);         // clamps to 8 steps
      idle_chk();

      run_seq(8, -1, 1, 0);          // prog_wr/start during run ignored
      idle_chk();
      run_seq(1, -1, 0, 0);          // mem[0] still 0
      idle_chk();
      prog_wr = 1'b1; prog_addr = 3'd1; prog_data = 3'd5;
      mem_model[1] = 3'd5;
      run_seq(2, -1, 0, 0);          // write coinciding with start is seen
      idle_chk();

      for (int i = 0; i < 8; i++) exp_q.push_back(mem_model[i]);
      base = drv_cnt;
      len = 4'd8; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!(drv_cnt == base + 3 && !x_valid) && cyc < 40) begin
         @(negedge clock);
         cyc++;
      end
      check("rst_reach", 32'(drv_cnt - base), 3);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      check("mrst_busy", 32'(busy), 0);
      check("mrst_xv", 32'(x_valid), 0);
      check("mrst_done", 32'(done), 0);
      check("mrst_x", 32'(x_out), 0);
      check("mrst_step", 32'(step), 0);
      check("mrst_zvec", 32'(z_vec), 0);
      check("mrst_abort", 32'(aborted), 0);
      dcnt = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) dcnt++;
      end
      check("mrst_nodone", 32'(dcnt), 0);
      for (int i = 0; i < 8; i++) mem_model[i] = 3'd0;
      run_seq(2, -1, 0, 0);          // memory cleared by reset
      idle_chk();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
